// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: DEPTH-stage delay line for the decoded bundle {valid, data, tag, wr, load}.
// Latency: DEPTH cycles in_* -> out_*; hazard/load_use are combinational from stage regs + src0/src1.
// Backpressure: stall freezes every stage; squash bubbles stages 0..SQUASH_DEPTH-1 even while stalled.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset (priority over stall and squash)
//   in_*              decoded instruction presented at decode output
//   stall, squash     global hold / kill of the incoming and leading in-flight instructions
//   src0, src1        source tags of the instruction in decode, for hazard checking
//   out_*             stage DEPTH-1 contents (out_wr already qualified by valid)
//   stage_valid/_tag  per-stage taps for the hazard controller, stage k at bit/slice k
//   occupancy         registered count of valid stages
//   hazard, load_use  in-flight RAW match / load in stage 0 feeding a source
// Build option: DECODE_CTRL_PIPE_HAZARD_EN builds the tag comparators; when undefined,
// hazard and load_use are tied low and src0/src1 are ignored.

module decode_ctrl_pipe #(
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 5,
    parameter int DEPTH        = 3,
    parameter int SQUASH_DEPTH = 1,
    localparam int OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_wr,
    input  logic                     in_load,
    input  logic                     stall,
    input  logic                     squash,
    input  logic [TAG_W-1:0]         src0,
    input  logic [TAG_W-1:0]         src1,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_wr,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH*TAG_W-1:0]   stage_tag,
    output logic [OCC_W-1:0]         occupancy,
    output logic                     hazard,
    output logic                     load_use
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              wr;
        logic              load;
    } stage_t;

    stage_t           stage_q [DEPTH];
    stage_t           stage_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Stage next-state: hold by default, shift when not stalled, then squash
    // overrides the leading stages. With stall=0 the bubbles in stages
    // 1..SQUASH_DEPTH-1 replace the killed in-flight instructions that would
    // have shifted in; with stall=1 they replace the held ones.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (!stall) begin
            stage_d[0].valid = in_valid;
            stage_d[0].data  = in_data;
            stage_d[0].tag   = in_tag;
            stage_d[0].wr    = in_wr & in_valid;
            stage_d[0].load  = in_load & in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
        if (squash) begin
            for (int k = 0; k < SQUASH_DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end
    end

    // Occupancy by net change. Without stall, squash kills old stages
    // 0..SQUASH_DEPTH-2 (they were about to move into the bubbled region);
    // with stall it kills old stages 0..SQUASH_DEPTH-1 in place. The last
    // stage leaves through the output only when not stalled.
    logic             pipe_in;
    logic             pipe_out;
    logic [OCC_W-1:0] cleared_cnt;

    always_comb begin
        pipe_in     = in_valid & ~stall & ~squash;
        pipe_out    = stage_q[DEPTH-1].valid & ~stall;
        cleared_cnt = '0;
        for (int k = 0; k < SQUASH_DEPTH; k++) begin
            if (squash && (stall || (k < SQUASH_DEPTH - 1))) begin
                cleared_cnt = cleared_cnt + OCC_W'(stage_q[k].valid);
            end
        end
        occ_d = occ_q + OCC_W'(pipe_in) - OCC_W'(pipe_out) - cleared_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            occ_q <= occ_d;
        end
    end

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_data  = stage_q[DEPTH-1].data;
    assign out_tag   = stage_q[DEPTH-1].tag;
    assign out_wr    = stage_q[DEPTH-1].wr & stage_q[DEPTH-1].valid;
    assign occupancy = occ_q;

    always_comb begin
        stage_valid = '0;
        stage_tag   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_valid[k]                = stage_q[k].valid;
            stage_tag[k*TAG_W +: TAG_W]   = stage_q[k].tag;
        end
    end

`ifdef DECODE_CTRL_PIPE_HAZARD_EN
    // x0 is hardwired zero, so a tag-0 writer can never feed a source.
    logic match0;
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (stage_q[k].valid && stage_q[k].wr && (stage_q[k].tag != '0) &&
                ((stage_q[k].tag == src0) || (stage_q[k].tag == src1))) begin
                hazard = 1'b1;
            end
        end
        match0 = stage_q[0].valid & stage_q[0].wr & (stage_q[0].tag != '0) &
                 ((stage_q[0].tag == src0) | (stage_q[0].tag == src1));
        load_use = match0 & stage_q[0].load;
    end
`else
    assign hazard   = 1'b0;
    assign load_use = 1'b0;
`endif

    // The last stage's load flag has no consumer; sources are unused
    // when the comparators are not built.
    logic unused_sink;
    assign unused_sink = stage_q[DEPTH-1].load ^ (^src0) ^ (^src1);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

`ifdef DECODE_CTRL_PIPE_HAZARD_EN
    localparam bit HZ_ON = 1'b1;
`else
    localparam bit HZ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_tag;
    logic        in_wr;
    logic        in_load;
    logic        stall;
    logic        squash;
    logic [4:0]  src0;
    logic [4:0]  src1;

    // DEPTH=3, SQUASH_DEPTH=2 instance
    logic        o3_valid, o3_wr, hz3, lu3;
    logic [31:0] o3_data;
    logic [4:0]  o3_tag;
    logic [2:0]  sv3;
    logic [14:0] st3;
    logic [1:0]  occ3;
    // DEPTH=1, SQUASH_DEPTH=1 instance
    logic        o1_valid, o1_wr, hz1, lu1;
    logic [31:0] o1_data;
    logic [4:0]  o1_tag;
    logic [0:0]  sv1;
    logic [4:0]  st1;
    logic [0:0]  occ1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.DATA_W(32), .TAG_W(5), .DEPTH(3), .SQUASH_DEPTH(2)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
        .in_wr(in_wr), .in_load(in_load), .stall(stall), .squash(squash),
        .src0(src0), .src1(src1), .out_valid(o3_valid), .out_data(o3_data),
        .out_tag(o3_tag), .out_wr(o3_wr), .stage_valid(sv3), .stage_tag(st3),
        .occupancy(occ3), .hazard(hz3), .load_use(lu3)
    );

    decode_ctrl_pipe #(.DATA_W(32), .TAG_W(5), .DEPTH(1), .SQUASH_DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
        .in_wr(in_wr), .in_load(in_load), .stall(stall), .squash(squash),
        .src0(src0), .src1(src1), .out_valid(o1_valid), .out_data(o1_data),
        .out_tag(o1_tag), .out_wr(o1_wr), .stage_valid(sv1), .stage_tag(st1),
        .occupancy(occ1), .hazard(hz1), .load_use(lu1)
    );

    // Reference model: each instance is a plain array of entries, index 0 = stage 0.
    typedef struct packed {
        bit        v;
        bit [31:0] d;
        bit [4:0]  t;
        bit        w;
        bit        l;
    } ent_t;

    ent_t m [2][8];
    int   dep [2] = '{3, 1};
    int   sqd [2] = '{2, 1};

    task automatic drive(input bit v, input bit [31:0] d, input bit [4:0] t,
                         input bit w, input bit l);
        in_valid = v; in_data = d; in_tag = t; in_wr = w; in_load = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input int i);
        ent_t old [8];
        ent_t e;
        for (int k = 0; k < 8; k++) old[k] = m[i][k];
        e.v = in_valid; e.d = in_data; e.t = in_tag;
        e.w = in_wr & in_valid; e.l = in_load & in_valid;
        if (!rst) begin
            for (int k = 0; k < 8; k++) m[i][k] = '0;
        end else begin
            if (!stall) begin
                m[i][0] = e;
                for (int k = 1; k < dep[i]; k++) m[i][k] = old[k-1];
            end
            if (squash) begin
                for (int k = 0; k < sqd[i]; k++) m[i][k] = '0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b1; squash = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
        src0 = 5'd7; src1 = 5'd7;
        tick(); tick();
        n_chk++;
        if ({o3_valid, o3_data, o3_tag, o3_wr, sv3, st3, occ3, hz3, lu3} !== '0) begin
            n_fail++;
            $display("FAIL reset_d3 got v=%b d=%h t=%0d sv=%b st=%h occ=%0d hz=%b lu=%b, expected all zero",
                     o3_valid, o3_data, o3_tag, sv3, st3, occ3, hz3, lu3);
        end
        n_chk++;
        if ({o1_valid, o1_data, o1_tag, o1_wr, sv1, st1, occ1, hz1, lu1} !== '0) begin
            n_fail++;
            $display("FAIL reset_d1 got v=%b d=%h t=%0d occ=%0d, expected all zero",
                     o1_valid, o1_data, o1_tag, occ1);
        end
        rst = 1'b1; stall = 1'b0; squash = 1'b0;
    endtask

    // Tags 1..6 back to back; leaves the pipe full with 6,5,4 in stages 0,1,2.
    task automatic test_fill();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'hA000 + i, 5'(i), 1'b1, 1'b0);
            tick();
            n_chk++;
            if (int'(occ3) != ((i < 3) ? i : 3)) begin
                n_fail++;
                $display("FAIL fill_occ cycle %0d got %0d expected %0d", i, occ3, (i < 3) ? i : 3);
            end
            n_chk++;
            if (i >= 3) begin
                if ({o3_valid, o3_wr, o3_tag, o3_data} !== {1'b1, 1'b1, 5'(i - 2), 32'hA000 + i - 2}) begin
                    n_fail++;
                    $display("FAIL fill_out cycle %0d got v=%b wr=%b tag=%0d data=%h expected tag %0d",
                             i, o3_valid, o3_wr, o3_tag, o3_data, i - 2);
                end
            end else if (o3_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_out cycle %0d got valid %b expected 0", i, o3_valid);
            end
            n_chk++;
            if ({o1_valid, o1_tag} !== {1'b1, 5'(i)}) begin
                n_fail++;
                $display("FAIL fill_d1 cycle %0d got v=%b tag=%0d expected tag %0d", i, o1_valid, o1_tag, i);
            end
        end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'($urandom), $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            tick();
            n_chk++;
            if ({sv3, st3, occ3} !== {3'b111, 5'd4, 5'd5, 5'd6, 2'd3}) begin
                n_fail++;
                $display("FAIL stall_taps cycle %0d got sv=%b st=%h occ=%0d expected sv=111 tags 4,5,6 occ=3",
                         c, sv3, st3, occ3);
            end
            n_chk++;
            if ({o3_valid, o3_wr, o3_tag, o3_data} !== {1'b1, 1'b1, 5'd4, 32'hA004}) begin
                n_fail++;
                $display("FAIL stall_out cycle %0d got tag=%0d data=%h expected tag 4 data a004",
                         c, o3_tag, o3_data);
            end
            n_chk++;
            if ({o1_valid, o1_tag} !== {1'b1, 5'd6}) begin
                n_fail++;
                $display("FAIL stall_d1 cycle %0d got v=%b tag=%0d expected tag 6", c, o1_valid, o1_tag);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_squash_stall();
        // Inject 9,8,7 so stage 2 holds 9 when full.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hB000 + i, 5'(9 - i), 1'b1, 1'b0);
            tick();
        end
        stall = 1'b1; squash = 1'b1;
        tick();
        n_chk++;
        if ({sv3, st3, occ3} !== {3'b100, 5'd9, 10'd0, 2'd1}) begin
            n_fail++;
            $display("FAIL squash_stall got sv=%b st=%h occ=%0d expected sv=100 tag 9 in stage 2 occ=1",
                     sv3, st3, occ3);
        end
        n_chk++;
        if ({o1_valid, occ1} !== 2'b00) begin
            n_fail++;
            $display("FAIL squash_d1 got v=%b occ=%0d expected 0 0", o1_valid, occ1);
        end
        squash = 1'b0;
        tick();
        n_chk++;
        if ({o3_valid, o3_tag, occ3} !== {1'b1, 5'd9, 2'd1}) begin
            n_fail++;
            $display("FAIL squash_hold got v=%b tag=%0d occ=%0d expected 1 9 1", o3_valid, o3_tag, occ3);
        end
        stall = 1'b0; in_valid = 1'b0;
        tick();
        n_chk++;
        if ({o3_valid, o3_wr, occ3} !== 4'b0000) begin
            n_fail++;
            $display("FAIL squash_drain got v=%b wr=%b occ=%0d expected 0 0 0", o3_valid, o3_wr, occ3);
        end
    endtask

    task automatic test_hazard();
        rst = 1'b0; stall = 1'b0; squash = 1'b0; tick(); rst = 1'b1;
        drive(1'b1, 32'h5, 5'd5, 1'b1, 1'b1); tick();
        drive(1'b1, 32'h0, 5'd0, 1'b1, 1'b1); tick();
        stall = 1'b1; in_valid = 1'b0;
        src0 = 5'd5; src1 = 5'd0; #1;
        n_chk++;
        if ({hz3, lu3} !== {HZ_ON, 1'b0}) begin
            n_fail++;
            $display("FAIL hz_stage1 got hz=%b lu=%b expected %b 0", hz3, lu3, HZ_ON);
        end
        src0 = 5'd0; src1 = 5'd0; #1;
        n_chk++;
        if ({hz3, lu3} !== 2'b00) begin
            n_fail++;
            $display("FAIL hz_x0 got hz=%b lu=%b expected 0 0", hz3, lu3);
        end
        // Load writer of tag 5 in stage 0.
        stall = 1'b0; rst = 1'b0; tick(); rst = 1'b1;
        drive(1'b1, 32'h5, 5'd5, 1'b1, 1'b1); tick();
        stall = 1'b1; in_valid = 1'b0;
        src0 = 5'd5; src1 = 5'd3; #1;
        n_chk++;
        if ({hz3, lu3, hz1, lu1} !== {4{HZ_ON}}) begin
            n_fail++;
            $display("FAIL lu_src0 got hz3=%b lu3=%b hz1=%b lu1=%b expected all %b", hz3, lu3, hz1, lu1, HZ_ON);
        end
        src0 = 5'd3; src1 = 5'd5; #1;
        n_chk++;
        if ({hz3, lu3} !== {2{HZ_ON}}) begin
            n_fail++;
            $display("FAIL lu_src1 got hz=%b lu=%b expected %b %b", hz3, lu3, HZ_ON, HZ_ON);
        end
        src0 = 5'd3; src1 = 5'd3; #1;
        n_chk++;
        if ({hz3, lu3} !== 2'b00) begin
            n_fail++;
            $display("FAIL lu_nomatch got hz=%b lu=%b expected 0 0", hz3, lu3);
        end
        // Non-load writer in stage 0: hazard but no load-use.
        stall = 1'b0; drive(1'b1, 32'h6, 5'd6, 1'b1, 1'b0); tick();
        stall = 1'b1; in_valid = 1'b0;
        src0 = 5'd6; src1 = 5'd0; #1;
        n_chk++;
        if ({hz3, lu3} !== {HZ_ON, 1'b0}) begin
            n_fail++;
            $display("FAIL hz_alu got hz=%b lu=%b expected %b 0", hz3, lu3, HZ_ON);
        end
        stall = 1'b0;
    endtask

    task automatic test_random();
        logic [88:0] obs;
        logic [88:0] exp_v;
        int          obs_occ;
        int          obs_pop;
        int          exp_occ;
        bit [7:0]    esv;
        bit [39:0]   est;
        bit          eh;
        bit          el;
        ent_t        top;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst      = (cyc == 0) ? 1'b0 : (($urandom % 100) != 0);
            stall    = (($urandom % 4) == 0);
            squash   = (($urandom % 8) == 0);
            drive((($urandom % 4) != 0), $urandom, 5'($urandom % 8), 1'($urandom), 1'($urandom));
            src0     = 5'($urandom % 8);
            src1     = 5'($urandom % 8);
            tick();
            for (int i = 0; i < 2; i++) begin
                model_step(i);
                esv = '0; est = '0; eh = 1'b0; el = 1'b0; exp_occ = 0;
                for (int k = 0; k < dep[i]; k++) begin
                    esv[k] = m[i][k].v;
                    est[k*5 +: 5] = m[i][k].t;
                    if (m[i][k].v) exp_occ++;
                    if (m[i][k].v && m[i][k].w && m[i][k].t != 0 &&
                        (m[i][k].t == src0 || m[i][k].t == src1)) begin
                        eh = 1'b1;
                        if (k == 0 && m[i][0].l) el = 1'b1;
                    end
                end
                eh = eh & HZ_ON;
                el = el & HZ_ON;
                top = m[i][dep[i] - 1];
                exp_v = {top.v, top.d, top.t, top.v & top.w, esv, est, eh, el};
                if (i == 0) begin
                    obs     = {o3_valid, o3_data, o3_tag, o3_wr, 8'(sv3), 40'(st3), hz3, lu3};
                    obs_occ = int'(occ3);
                    obs_pop = $countones(sv3);
                end else begin
                    obs     = {o1_valid, o1_data, o1_tag, o1_wr, 8'(sv1), 40'(st1), hz1, lu1};
                    obs_occ = int'(occ1);
                    obs_pop = $countones(sv1);
                end
                n_chk++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rand_outputs inst%0d cycle %0d got %h expected %h", i, cyc, obs, exp_v);
                end
                n_chk++;
                if (obs_occ != exp_occ) begin
                    n_fail++;
                    $display("FAIL rand_occ inst%0d cycle %0d got %0d expected %0d", i, cyc, obs_occ, exp_occ);
                end
                n_chk++;
                if (obs_occ != obs_pop) begin
                    n_fail++;
                    $display("FAIL rand_occ_pop inst%0d cycle %0d occupancy %0d popcount %0d", i, cyc, obs_occ, obs_pop);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; squash = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        src0 = 5'd0; src1 = 5'd0;
        test_reset();
        test_fill();
        test_stall_hold();
        test_squash_stall();
        test_hazard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
